sevenseg_scan_n: RTL and testbench

SEVENSEG_SCAN_N -- requirements
Module: sevenseg_scan_n

---
 rtl/sevenseg_scan_n.sv | 161 ++++++++++++++++
 tb/tb_sevenseg_scan_n.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_n.sv
// Multiplexed N-digit seven-segment scanner with per-slot blanking, leading-zero suppression and PWM dimming.
// Outputs registered: one cycle latency from scan state; no backpressure (free-running display driver).
module sevenseg_scan_n #(
    parameter int DIGITS          = 4,
    parameter int TICKS_PER_DIGIT = 25_000,
    parameter int BLANK_TICKS     = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_en,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  lz_blank,
    input  logic [3:0]            brightness,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_tick
);

    localparam int DVW = $clog2(TICKS_PER_DIGIT);
    localparam int DGW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } slot_st_e;

    localparam slot_st_e ST_RESET = (BLANK_TICKS > 0) ? ST_BLANK : ST_ON;

    logic [DVW-1:0]      div_q, div_d;
    logic [DGW-1:0]      digit_q, digit_d;
    logic [3:0]          pwm_q;
    slot_st_e            state_q, state_d;

    logic [4*DIGITS-1:0] val_snap_q;
    logic [DIGITS-1:0]   dp_snap_q;
    logic [DIGITS-1:0]   den_snap_q;
    logic                lz_snap_q;

    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic                frame_tick_q;

    logic                last_div;
    logic                frame_wrap;
    logic                lit;
    logic [DIGITS-1:0]   lz_mask;
    logic                zero_run;
    logic [3:0]          cur_nib;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        case (nib)
            4'h0: hex_glyph = 7'b1000000;
            4'h1: hex_glyph = 7'b1111001;
            4'h2: hex_glyph = 7'b0100100;
            4'h3: hex_glyph = 7'b0110000;
            4'h4: hex_glyph = 7'b0011001;
            4'h5: hex_glyph = 7'b0010010;
            4'h6: hex_glyph = 7'b0000010;
            4'h7: hex_glyph = 7'b1111000;
            4'h8: hex_glyph = 7'b0000000;
            4'h9: hex_glyph = 7'b0010000;
            4'hA: hex_glyph = 7'b0001000;
            4'hB: hex_glyph = 7'b0000011;
            4'hC: hex_glyph = 7'b1000110;
            4'hD: hex_glyph = 7'b0100001;
            4'hE: hex_glyph = 7'b0000110;
            default: hex_glyph = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        last_div   = (div_q == DVW'(TICKS_PER_DIGIT - 1));
        frame_wrap = last_div && (digit_q == DGW'(DIGITS - 1));
        div_d      = last_div ? '0 : div_q + DVW'(1);
        digit_d    = digit_q;
        if (last_div) begin
            digit_d = frame_wrap ? '0 : digit_q + DGW'(1);
        end
    end

    // Slot phase tracks the counter value being loaded so it lines up with div_q.
    generate
        if (BLANK_TICKS == 0) begin : g_no_blank
            always_comb begin
                state_d = ST_ON;
            end
        end else begin : g_blank
            always_comb begin
                state_d = ST_ON;
                if (div_d < DVW'(BLANK_TICKS)) begin
                    state_d = ST_BLANK;
                end
            end
        end
    endgenerate

    // A digit is suppressed when it and every digit above it are zero; digit 0 always survives.
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run & (val_snap_q[4*i +: 4] == 4'h0);
            lz_mask[i] = lz_snap_q & zero_run;
        end
    end

    always_comb begin
        cur_nib = val_snap_q[{digit_q, 2'b00} +: 4];
        lit     = (state_q == ST_ON) && den_snap_q[digit_q] && !lz_mask[digit_q]
                  && (pwm_q <= brightness);
        an_d    = '1;
        seg_d   = 7'b1111111;
        dp_d    = 1'b1;
        if (lit) begin
            an_d  = ~(DIGITS'(1) << digit_q);
            seg_d = hex_glyph(cur_nib);
            dp_d  = ~dp_snap_q[digit_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= '0;
            digit_q      <= '0;
            pwm_q        <= '0;
            state_q      <= ST_RESET;
            val_snap_q   <= '0;
            dp_snap_q    <= '0;
            den_snap_q   <= '0;
            lz_snap_q    <= 1'b0;
            an_q         <= '1;
            seg_q        <= 7'b1111111;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            digit_q      <= digit_d;
            pwm_q        <= pwm_q + 4'd1;
            state_q      <= state_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_wrap;
            if (frame_wrap) begin
                val_snap_q <= value;
                dp_snap_q  <= dp_en;
                den_snap_q <= digit_en;
                lz_snap_q  <= lz_blank;
            end
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sevenseg_scan_n.sv
// Bench for sevenseg_scan_n: time-indexed reference model for two scan rates plus directed frame checks.
module tb_sevenseg_scan_n;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp_en = '0;
    logic [3:0]  digit_en = '0;
    logic        lz_blank = 1'b0;
    logic [3:0]  brightness = 4'd15;

    logic [3:0]  an8, an40;
    logic [6:0]  seg8, seg40;
    logic        dp8, dp40, ft8, ft40;

    sevenseg_scan_n #(.DIGITS(4), .TICKS_PER_DIGIT(8), .BLANK_TICKS(2)) dut8 (
        .clk(clk), .rst(rst), .value(value), .dp_en(dp_en), .digit_en(digit_en),
        .lz_blank(lz_blank), .brightness(brightness),
        .an(an8), .seg(seg8), .dp(dp8), .frame_tick(ft8)
    );

    sevenseg_scan_n #(.DIGITS(4), .TICKS_PER_DIGIT(40), .BLANK_TICKS(2)) dut40 (
        .clk(clk), .rst(rst), .value(value), .dp_en(dp_en), .digit_en(digit_en),
        .lz_blank(lz_blank), .brightness(brightness),
        .an(an40), .seg(seg40), .dp(dp40), .frame_tick(ft40)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {an, seg, dp} for the t-th cycle after reset release, from the scan timing rules.
    function automatic logic [11:0] mdl(input int tpd, input int t, input logic [15:0] v,
                                        input logic [3:0] den, input logic [3:0] dpe,
                                        input logic lz, input logic [3:0] br);
        int dv  = t % tpd;
        int d   = (t / tpd) % 4;
        int pwm = t % 16;
        int hi  = 0;
        for (int i = 0; i < 4; i++) if (v[4*i +: 4] != 4'h0) hi = i;
        if (dv >= 2 && den[d] && (!lz || d <= hi) && pwm <= int'(br))
            return {~(4'b0001 << d), glyph[v[4*d +: 4]], ~dpe[d]};
        return {4'hF, 7'h7F, 1'b1};
    endfunction

    int          tm   [2];
    logic [15:0] sv   [2];
    logic [3:0]  sden [2];
    logic [3:0]  sdp  [2];
    logic        slz  [2];
    logic [12:0] expv [2];

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            int   tp;
            logic ftx;
            tp = (m == 0) ? 8 : 40;
            if (rst) begin
                expv[m] = {4'hF, 7'h7F, 1'b1, 1'b0};
                tm[m] = 0; sv[m] = '0; sden[m] = '0; sdp[m] = '0; slz[m] = 1'b0;
            end else begin
                ftx = ((tm[m] % (4*tp)) == 4*tp - 1);
                expv[m] = {mdl(tp, tm[m], sv[m], sden[m], sdp[m], slz[m], brightness), ftx};
                if (ftx) begin
                    sv[m] = value; sden[m] = digit_en; sdp[m] = dp_en; slz[m] = lz_blank;
                end
                tm[m]++;
            end
        end
        #1;
        chk("model_t8", {an8, seg8, dp8, ft8}, expv[0]);
        chk("model_t40", {an40, seg40, dp40, ft40}, expv[1]);
        chk("onehot_an", ($countones(~an8) <= 1 && $countones(~an40) <= 1), 1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ft(input int which, input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (((which == 8) ? ft8 : ft40) !== 1'b1 && n < budget);
        chk("wait_frame_tick", (which == 8) ? ft8 : ft40, 1);
    endtask

    // Starts on a frame_tick cycle of dut8, checks one full frame, ends on the next frame_tick.
    task automatic check_frame(input string tag, input logic [27:0] segs, input logic [3:0] lit,
                               input logic [15:0] newv, input logic newlz);
        for (int k = 1; k <= 32; k++) begin
            int d, dv;
            logic [11:0] e;
            step();
            d  = (k - 1) / 8;
            dv = (k - 1) % 8;
            if (dv >= 2 && lit[d]) e = {~(4'b0001 << d), segs[7*d +: 7], ~dp_en[d]};
            else                   e = {4'hF, 7'h7F, 1'b1};
            chk(tag, {an8, seg8, dp8}, e);
            if (k == 10) begin
                value    = newv;
                lz_blank = newlz;
            end
        end
        chk({tag, "_ft"}, ft8, 1);
    endtask

    initial begin
        int cnt;
        int n;

        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_outputs", {an8, seg8, dp8, ft8}, {4'hF, 7'h7F, 1'b1, 1'b0});
        end
        rst = 1'b0; value = 16'h12AF; digit_en = 4'hF; dp_en = 4'b0001;
        brightness = 4'd15; lz_blank = 1'b0;
        step();
        chk("post_reset_outputs", {an8, seg8, dp8, ft8}, {4'hF, 7'h7F, 1'b1, 1'b0});
        wait_ft(8, 100);

        check_frame("frame_12AF", {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'b1111,
                    16'h0030, 1'b1);
        check_frame("frame_lz_0030", {7'b1111111, 7'b1111111, 7'b0110000, 7'b1000000}, 4'b0011,
                    16'h0000, 1'b1);
        check_frame("frame_lz_0000", {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b0001,
                    16'h1111, 1'b0);
        check_frame("frame_1111_change", {4{7'b1111001}}, 4'b1111, 16'h2222, 1'b0);
        check_frame("frame_2222", {4{7'b0100100}}, 4'b1111, 16'h2222, 1'b0);

        brightness = 4'd0;
        wait_ft(40, 400);
        cnt = 0;
        for (int k = 1; k <= 18; k++) begin
            step();
            if (k >= 3 && an40 != 4'hF) cnt++;
        end
        chk("pwm_bright0", cnt, 1);
        brightness = 4'd7;
        cnt = 0;
        for (int k = 19; k <= 34; k++) begin
            step();
            if (an40 != 4'hF) cnt++;
        end
        chk("pwm_bright7", cnt, 8);
        brightness = 4'd15;

        for (int c = 0; c < 700; c++) begin
            step();
            if ($urandom_range(0, 7) == 0)  value      = 16'($urandom);
            if ($urandom_range(0, 15) == 0) value      = {12'h000, 4'($urandom)};
            if ($urandom_range(0, 15) == 0) digit_en   = 4'($urandom);
            if ($urandom_range(0, 15) == 0) dp_en      = 4'($urandom);
            if ($urandom_range(0, 15) == 0) lz_blank   = 1'($urandom);
            if ($urandom_range(0, 3) == 0)  brightness = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 249) == 0);
        end
        rst = 1'b0; value = 16'h2222; digit_en = 4'hF; dp_en = 4'b0001;
        lz_blank = 1'b0; brightness = 4'd15;
        step();

        wait_ft(8, 100);
        wait_ft(8, 100);
        for (int k = 1; k <= 21; k++) step();
        chk("pre_reset_digit2", an8, 4'b1011);
        rst = 1'b1;
        step();
        chk("midframe_reset_an", an8, 4'hF);
        chk("midframe_reset_seg", seg8, 7'h7F);
        chk("midframe_reset_dp", dp8, 1);
        rst = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (ft8 !== 1'b1 && n < 100);
        chk("first_ft_after_reset", n, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
